// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared constants and state type for the TCP to sign-magnitude decoder
//
// Contents:
//   DEFAULT_DATA_WIDTH   default operand width
//   ST_IDLE/CONV/DONE    decoder state encodings
//   tcp_state_t          enumerated state type built on those encodings
//   FUNC_TCP/FUNC_ZERO   ALU helper-path function codes

package tcp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CONV = ST_CONV,
        DONE = ST_DONE
    } tcp_state_t;

    // ALU function codes for the forward TCP/ZERO helper path.
    localparam logic [3:0] FUNC_TCP  = 4'd8;
    localparam logic [3:0] FUNC_ZERO = 4'd9;

endpackage

// File: rtl/tcp_serial_neg_cell.sv
// rtl/tcp_serial_neg_cell.sv - one-bit cell of LSB-first serial two's-complement negation
//
// Ports:
//   b              current operand bit (LSB first)
//   seen_one       a 1 has already been consumed in a lower bit position
//   r              negated result bit
//   seen_one_next  updated seen_one flag for the next bit

module tcp_serial_neg_cell (
    input  logic b,
    input  logic seen_one,
    output logic r,
    output logic seen_one_next
);

    // Bits up to and including the first 1 pass through; later bits invert.
    assign r             = b ^ seen_one;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/tcp_sm_decoder.sv
// rtl/tcp_sm_decoder.sv - multi-cycle two's-complement to sign-magnitude converter
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready       operand handshake, in_data is the two's-complement operand
//   out_valid/out_ready     result handshake
//   out_sign, out_mag       sign-magnitude result
//   out_of                  operand was the most-negative value

module tcp_sm_decoder
    import tcp_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [data_width-1:0] out_mag,
    output logic                  out_of
);

    localparam int                   cw       = $clog2(data_width);
    localparam logic [cw-1:0]        cnt_one  = cw'(1);
    localparam logic [cw-1:0]        cnt_last = cw'(data_width - 2);
    localparam logic [data_width-1:0] most_neg = {1'b1, {(data_width - 1){1'b0}}};

    tcp_state_t state, state_next;

    // Only the low data_width-1 bits need serial negation: the magnitude MSB of a
    // negative operand is 0 unless the operand is the most-negative value, where it
    // is 1 and is supplied by the overflow flag instead.
    logic [data_width-2:0] sr;
    logic [data_width-2:0] mag_sr;
    logic [data_width-2:0] mag_next;
    logic [data_width-1:0] shift_in;
    logic [cw-1:0]         cnt;
    logic                  seen_one;
    logic                  seen_one_next;
    logic                  r;
    logic                  is_of;
    logic                  accept;
    logic                  last_bit;

    tcp_serial_neg_cell u_cell (
        .b             (sr[0]),
        .seen_one      (seen_one),
        .r             (r),
        .seen_one_next (seen_one_next)
    );

    assign shift_in = {r, mag_sr};
    assign mag_next = shift_in[data_width-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = in_data[data_width-1] ? CONV : DONE;
                end
            end
            CONV: begin
                if (cnt == cnt_last) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr       <= '0;
            mag_sr   <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            is_of    <= 1'b0;
            out_sign <= 1'b0;
            out_mag  <= '0;
            out_of   <= 1'b0;
        end else if (accept) begin
            sr       <= in_data[data_width-2:0];
            mag_sr   <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            is_of    <= (in_data == most_neg);
            if (!in_data[data_width-1]) begin
                out_sign <= 1'b0;
                out_mag  <= in_data;
                out_of   <= 1'b0;
            end
        end else if (state == CONV) begin
            sr       <= sr >> 1;
            mag_sr   <= mag_next;
            seen_one <= seen_one_next;
            cnt      <= cnt + cnt_one;
            if (last_bit) begin
                out_sign <= 1'b1;
                out_mag  <= {is_of, mag_next};
                out_of   <= is_of;
            end
        end
    end

endmodule

// File: tb/tb_tcp_sm_decoder.sv
// tb/tb_tcp_sm_decoder.sv - self-checking bench for tcp_sm_decoder

module tb_tcp_sm_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [15:0] out_mag;
    logic        out_of;

    int n_assert = 0;
    int n_fail   = 0;

    tcp_sm_decoder #(.data_width(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_of    (out_of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; model derives the result arithmetically.
    task automatic collect(input logic [15:0] d, input int hold);
        int          lat;
        int          exp_lat;
        logic        exp_sign;
        logic        exp_of;
        logic [15:0] exp_mag;
        exp_sign = d[15];
        exp_mag  = exp_sign ? 16'(~d + 16'd1) : d;
        exp_of   = (d == 16'h8000);
        exp_lat  = exp_sign ? 16 : 1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_data  = 16'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("sign", out_sign, exp_sign);
        chk("mag", out_mag, exp_mag);
        chk("of", out_of, exp_of);
        chk("busy_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_data  = 16'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_sign", out_sign, exp_sign);
            chk("hold_mag", out_mag, exp_mag);
            chk("hold_of", out_of, exp_of);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        logic [15:0] d;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sign", out_sign, 0);
        chk("rst_mag", out_mag, 0);
        chk("rst_of", out_of, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        send(16'h0005); collect(16'h0005, 0);
        send(16'hFFFB); collect(16'hFFFB, 0);
        send(16'h8000); collect(16'h8000, 0);

        // Back-to-back with in_valid held high across the result.
        in_data  = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_sign0", out_sign, 0);
        chk("b2b_mag0", out_mag, 16'h0000);
        chk("b2b_of0", out_of, 0);
        in_data   = 16'hFFFF;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_idle_ready", in_ready, 1);
        chk("b2b_idle_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_busy", in_ready, 0);
        collect(16'hFFFF, 0);

        send(16'hFF00); collect(16'hFF00, 5);

        // Reset in the middle of a conversion.
        send(16'h8001);
        repeat (6) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("midrst_no_result", seen, 0);
        end
        send(16'h0003); collect(16'h0003, 0);

        // Boundaries, then randomized operands.
        send(16'h7FFF); collect(16'h7FFF, 1);
        send(16'h0001); collect(16'h0001, 0);
        send(16'h8000); collect(16'h8000, 2);
        for (int k = 0; k < 24; k++) begin
            d = 16'($urandom);
            send(d);
            collect(d, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
